ex_mdu_iter: RTL

- Iterative multiply/divide unit for the EX stage, implementing the RV32M/RV64M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the ALU and is selected when the decoded mduop is not MDU_NONE.
- Operands arrive through a valid/ready handshake. The unit computes one bit per cycle, then holds the result until the EX/MEM side accepts it.
- The hazard unit stalls the pipeline while busy is high.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/ex_mdu_iter_if.sv | 33 +++
 rtl/ex_mdu_iter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation select, FSM states
// and a small decode helper.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE = 4'd0,
      MUL      = 4'd1,
      MULH     = 4'd2,
      MULHSU   = 4'd3,
      MULHU    = 4'd4,
      DIV      = 4'd5,
      DIVU     = 4'd6,
      REM      = 4'd7,
      REMU     = 4'd8
   } mduop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   function automatic logic is_div(input mduop_t op);
      return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/ex_mdu_iter_if.sv
// Operand/result handshake bundle between the EX stage and the multiply/divide unit.
// The master side offers operations and consumes results; the slave is the unit.
interface ex_mdu_iter_if
   import mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) ();

   logic              in_valid;
   logic              in_ready;
   mduop_t            mduop;
   logic [XLEN-1:0]   opr_a;
   logic [XLEN-1:0]   opr_b;
   logic [TAG_W-1:0]  rd_in;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   res;
   logic [TAG_W-1:0]  rd_out;
   logic              busy;

   modport master (
      output in_valid, mduop, opr_a, opr_b, rd_in, flush, out_ready,
      input  in_ready, out_valid, res, rd_out, busy
   );

   modport slave (
      input  in_valid, mduop, opr_a, opr_b, rd_in, flush, out_ready,
      output in_ready, out_valid, res, rd_out, busy
   );

endinterface

// File: rtl/ex_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle on magnitudes,
// sign correction on the final edge, result held until the consumer accepts it.
module ex_mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   ex_mdu_iter_if.slave mdu
);

   localparam int CW = $clog2(XLEN);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_CALC = CALC;
   localparam logic [1:0] ST_DONE = DONE;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state_reg, state_next;
   logic [CW-1:0]     count_reg;
   mduop_t            op_reg;
   logic [TAG_W-1:0]  rd_reg;
   logic [XLEN-1:0]   opnd_reg;      // multiplicand magnitude, or divisor magnitude
   logic [2*XLEN-1:0] prod_reg;      // {acc, multiplier} or {unused, dividend/quotient}
   logic [XLEN-1:0]   rem_reg;
   logic              neg_q_reg, neg_r_reg;
   logic [XLEN-1:0]   res_reg;

   logic              accept, last, sgn_a, sgn_b, div_zero, div_ovf, fast;
   logic [XLEN-1:0]   mag_a, mag_b, fast_res, final_res, quo_step, rem_step;
   logic [XLEN:0]     mul_sum, shifted, diff;
   logic [2*XLEN-1:0] prod_mul, prod_fix, prod_step;
   logic              q_bit;

   // Accept-time decode: signedness, magnitudes and the divide special cases
   always_comb begin
      accept   = mdu.in_valid && (state_reg == ST_IDLE) && (mdu.mduop != MDU_NONE) && !mdu.flush;
      sgn_a    = ((mdu.mduop == MULH) || (mdu.mduop == MULHSU) || (mdu.mduop == DIV) ||
                  (mdu.mduop == REM)) && mdu.opr_a[XLEN-1];
      sgn_b    = ((mdu.mduop == MULH) || (mdu.mduop == DIV) || (mdu.mduop == REM)) &&
                 mdu.opr_b[XLEN-1];
      mag_a    = sgn_a ? -mdu.opr_a : mdu.opr_a;
      mag_b    = sgn_b ? -mdu.opr_b : mdu.opr_b;
      div_zero = is_div(mdu.mduop) && (mdu.opr_b == '0);
      div_ovf  = ((mdu.mduop == DIV) || (mdu.mduop == REM)) &&
                 (mdu.opr_a == MIN_NEG) && (mdu.opr_b == '1);
      fast     = div_zero || div_ovf;
      fast_res = '0;
      if (div_zero)
         fast_res = ((mdu.mduop == DIV) || (mdu.mduop == DIVU)) ? '1 : mdu.opr_a;
      else if (mdu.mduop == DIV)
         fast_res = mdu.opr_a;
   end

   // One iteration of shift-add multiply or restoring divide, plus final selection
   always_comb begin
      last      = (state_reg == ST_CALC) && (count_reg == CW'(XLEN-1));
      mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, opnd_reg} : '0);
      prod_mul  = {mul_sum, prod_reg[XLEN-1:1]};
      shifted   = {rem_reg, prod_reg[XLEN-1]};
      diff      = shifted - {1'b0, opnd_reg};
      q_bit     = !diff[XLEN];
      rem_step  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_step  = {prod_reg[XLEN-2:0], q_bit};
      prod_step = is_div(op_reg) ? {{XLEN{1'b0}}, quo_step} : prod_mul;
      prod_fix  = neg_q_reg ? -prod_mul : prod_mul;
      case (op_reg)
         MUL:                 final_res = prod_fix[XLEN-1:0];
         MULH, MULHSU, MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         DIV, DIVU:           final_res = neg_q_reg ? -quo_step : quo_step;
         REM, REMU:           final_res = neg_r_reg ? -rem_step : rem_step;
         default:             final_res = '0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = fast ? ST_DONE : ST_CALC;
         ST_CALC: if (last) state_next = ST_DONE;
         ST_DONE: if (mdu.out_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (mdu.flush)
         state_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         op_reg    <= MDU_NONE;
         rd_reg    <= '0;
         opnd_reg  <= '0;
         prod_reg  <= '0;
         rem_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         res_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg    <= mdu.mduop;
            rd_reg    <= mdu.rd_in;
            neg_q_reg <= sgn_a ^ sgn_b;
            neg_r_reg <= sgn_a;
            count_reg <= '0;
            rem_reg   <= '0;
            opnd_reg  <= is_div(mdu.mduop) ? mag_b : mag_a;
            prod_reg  <= {{XLEN{1'b0}}, (is_div(mdu.mduop) ? mag_a : mag_b)};
            if (fast)
               res_reg <= fast_res;
         end else if (state_reg == ST_CALC) begin
            prod_reg <= prod_step;
            rem_reg  <= rem_step;
            if (!last)
               count_reg <= count_reg + 1'b1;
            else if (!mdu.flush)
               res_reg <= final_res;
         end
      end
   end

   assign mdu.in_ready  = (state_reg == ST_IDLE);
   assign mdu.out_valid = (state_reg == ST_DONE);
   assign mdu.busy      = (state_reg != ST_IDLE);
   assign mdu.res       = res_reg;
   assign mdu.rd_out    = rd_reg;

endmodule
